// File: rtl/vga_pixel_stream.sv
// vga_pixel_stream: buffers an SOF-marked pixel stream and locks it to the VGA raster.
// Outputs rgb/de/hsync/vsync with a fixed, mutually aligned 2-cycle latency.
module vga_pixel_stream #(
  parameter int WIDTH      = 10,
  parameter int PIX_W      = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] hcount,
  input  logic [WIDTH-1:0] vcount,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             locked,
  output logic             err,
  input  logic             err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {SEEK, WAIT, STREAM} state_t;
  state_t r_state, w_nxt;
  logic [PIX_W:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic r_rdy, r_act1, r_hs1, r_vs1;
  logic [PIX_W-1:0] r_pix1, w_pix, w_head_data;
  logic w_empty, w_full, w_push, w_pop, w_err, w_act, w_fstart, w_head_sof;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign s_ready  = r_rdy && !w_full;
  assign w_push   = s_valid && s_ready;
  assign {w_head_sof, w_head_data} = r_mem[r_rp[AW-1:0]];
  assign w_act    = !hblank_in && !vblank_in;
  assign w_fstart = w_act && hcount == '0 && vcount == '0;
  assign locked   = r_state == STREAM;
  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    w_err = 1'b0;
    w_pix = '0;
    case (r_state)
      SEEK: begin
        w_pop = !w_empty && !w_head_sof;
        w_nxt = (!w_empty && w_head_sof) ? WAIT : SEEK;
      end
      WAIT: if (w_fstart && !w_empty) begin
        w_pop = 1'b1;
        w_pix = w_head_data;
        w_nxt = STREAM;
      end
      default: if (w_act) begin
        // an SOF head must coincide exactly with fstart, otherwise the stream has slipped
        if (w_empty || (w_head_sof != w_fstart)) begin
          w_err = 1'b1;
          w_nxt = (!w_empty && w_head_sof) ? WAIT : SEEK;
        end else begin
          w_pop = 1'b1;
          w_pix = w_head_data;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {s_sof, s_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= SEEK;
      r_wp    <= '0;
      r_rp    <= '0;
      r_rdy   <= 1'b0;
      err     <= 1'b0;
      r_pix1  <= '0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      rgb     <= '0;
      de      <= 1'b0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wp    <= r_wp + {{AW{1'b0}}, w_push};
      r_rp    <= r_rp + {{AW{1'b0}}, w_pop};
      r_rdy   <= 1'b1;
      err     <= w_err || (err && !err_clr);
      r_pix1  <= w_pix;
      r_act1  <= w_act;
      r_hs1   <= hsync_in;
      r_vs1   <= vsync_in;
      rgb     <= r_act1 ? r_pix1 : '0;
      de      <= r_act1;
      hsync   <= r_hs1;
      vsync   <= r_vs1;
    end
endmodule

// File: tb/tb_vga_pixel_stream.sv
// tb_vga_pixel_stream: drives a reduced raster plus an SOF-marked stream and scoreboards
// rgb/de/hsync/vsync against the raster position two cycles earlier.
module tb_vga_pixel_stream;
  localparam int H_ACT = 32, H_TOT = 40, V_ACT = 8, V_TOT = 12, NPIX = H_ACT * V_ACT;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] hcount = '0, vcount = '0;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
  logic [11:0] s_data = '0;
  logic s_sof = 1'b0, s_valid = 1'b0, err_clr = 1'b0;
  logic s_ready, hsync, vsync, de, locked, err;
  logic [11:0] rgb;
  logic [14:0] sb [$];
  logic [12:0] src [$];
  int errors = 0, checks = 0, acc_cnt = 0, rv = V_ACT, rh = 0;
  bit post = 1'b0;

  always #5 clk = ~clk;

  vga_pixel_stream dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de), .locked(locked), .err(err),
    .err_clr(err_clr)
  );

  function automatic logic [11:0] f(int k, int idx);
    return 12'((idx + k * 300) % 4096);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(int k, int n);
    for (int i = 0; i < n; i++) src.push_back({i == 0, f(k, i)});
  endtask

  task automatic cyc(int k, int cut);
    int idx;
    logic act, acc;
    act = rh < H_ACT && rv < V_ACT;
    idx = rv * H_ACT + rh;
    hcount = 10'(rh);
    vcount = 10'(rv);
    hblank_in = rh >= H_ACT;
    vblank_in = rv >= V_ACT;
    hsync_in = rh >= 34 && rh < 38;
    vsync_in = rv >= 9 && rv < 11;
    s_valid = src.size() > 0;
    {s_sof, s_data} = s_valid ? src[0] : 13'h0;
    acc = s_valid && s_ready;
    sb.push_back({(act && idx < cut) ? f(k, idx) : 12'h0, act, hsync_in, vsync_in});
    @(posedge clk);
    #1;
    if (acc) begin
      void'(src.pop_front());
      acc_cnt++;
    end
    if (rh == H_TOT - 1) begin
      rh = 0;
      rv = (rv == V_TOT - 1) ? 0 : rv + 1;
    end else rh++;
    if (sb.size() >= 2) chk("pipe", 32'({rgb, de, hsync, vsync}), 32'(sb.pop_front()));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    chk("rst_outs", 32'({rgb, de, hsync, vsync, locked, err, s_ready}), 32'h0);
    rst = 1'b0;
    #1;
    sb.delete();
    src.delete();
    post = 1'b1;
  endtask

  // One raster period: 4 vblank lines followed by the 8 active lines of frame k.
  task automatic run_frame(int k, int cut, logic lk0, logic lk_end, logic err_end,
                           logic clr, logic bp, int rst_at);
    int a0;
    logic fs;
    a0 = acc_cnt;
    for (int n = 0; n < H_TOT * V_TOT; n++) begin
      if (rst_at >= 0 && rv < V_ACT && rh < H_ACT && rv * H_ACT + rh == rst_at) pulse_rst();
      fs = rv == 0 && rh == 0;
      err_clr = clr && n == 0;
      cyc(k, cut);
      err_clr = 1'b0;
      if (post) begin
        chk("ready_after_rst", 32'(s_ready), 32'h1);
        post = 1'b0;
      end
      if (clr && n == 0) chk("err_clr", 32'(err), 32'h0);
      if (fs) chk("locked_fstart", 32'(locked), 32'(lk0));
      if (bp && n == 20) begin
        chk("bp_ready", 32'(s_ready), 32'h0);
        chk("bp_count", 32'(acc_cnt - a0), 32'd16);
      end
    end
    chk("locked_end", 32'(locked), 32'(lk_end));
    chk("err_end", 32'(err), 32'(err_end));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({rgb, de, hsync, vsync, locked, err, s_ready}), 32'h0);
    rst = 1'b0;
    post = 1'b1;
    for (int i = 0; i < 5; i++) src.push_back({1'b0, 12'(12'hA00 + i)});
    push_frame(0, NPIX);
    run_frame(0, NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    push_frame(1, NPIX);
    run_frame(1, NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    push_frame(2, 3 * H_ACT + 10);
    push_frame(3, NPIX);
    run_frame(2, 3 * H_ACT + 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_frame(3, NPIX, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    push_frame(4, 10);
    run_frame(4, 10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    push_frame(5, NPIX);
    run_frame(5, NPIX, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    push_frame(6, NPIX);
    run_frame(6, 4 * H_ACT + 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4 * H_ACT + 12);
    push_frame(7, NPIX);
    run_frame(7, NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
